// File: rtl/event_dispatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | event_dispatch_pkg : handle-table entry type, null entry, reset mapping  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package event_dispatch_pkg;

  localparam int NUM_EV_DEF = 4;
  localparam int NUM_H_DEF  = 4;
  localparam int EW_DEF     = $clog2(NUM_EV_DEF);

  typedef struct packed {
    logic              valid;
    logic [EW_DEF-1:0] idx;
  } map_entry_t;

  localparam map_entry_t MAP_NULL = '{valid: 1'b0, idx: '0};

  // Handles below num_ev start bound to the event of the same number; the rest start null.
  function automatic map_entry_t map_reset(input int unsigned h, input int unsigned num_ev);
    map_entry_t e;
    e = MAP_NULL;
    if (h < num_ev) begin
      e.valid = 1'b1;
      e.idx   = EW_DEF'(h);
    end
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/event_handle_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | event_handle_map : handle -> event table, copy/null write, bypassed read |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module event_handle_map
  import event_dispatch_pkg::*;
#(
  parameter int NUM_EV = NUM_EV_DEF,
  parameter int NUM_H  = NUM_H_DEF,
  parameter int HW     = $clog2(NUM_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          asg_valid,
  input  logic [HW-1:0] asg_dst,
  input  logic [HW-1:0] asg_src,
  input  logic          asg_null,
  input  logic [HW-1:0] lk_handle,
  output map_entry_t    lk_entry
);

  map_entry_t r_map [NUM_H];
  map_entry_t w_wr_entry;

  // Source is read from the table as it stands before this cycle's write.
  assign w_wr_entry = asg_null ? MAP_NULL : r_map[asg_src];

  // A lookup of the handle being written sees the new value in the same cycle.
  assign lk_entry = (asg_valid && (asg_dst == lk_handle)) ? w_wr_entry : r_map[lk_handle];

  always_ff @(posedge clk) begin
    for (int h = 0; h < NUM_H; h++) begin
      if (rst) begin
        r_map[h] <= map_reset(h, NUM_EV);
      end else if (asg_valid && (asg_dst == HW'(h))) begin
        r_map[h] <= w_wr_entry;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/event_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | event_dispatch : resolves immediate/delayed handle triggers into event   |
// | fire pulses, sticky seen flags and a saturating dropped-trigger count.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module event_dispatch
  import event_dispatch_pkg::*;
#(
  parameter int NUM_EV = NUM_EV_DEF,
  parameter int NUM_H  = NUM_H_DEF,
  parameter int HW     = $clog2(NUM_H),
  parameter int EW     = $clog2(NUM_EV),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_valid,
  input  logic [HW-1:0]     trig_handle,
  input  logic              trig_delayed,
  input  logic              asg_valid,
  input  logic [HW-1:0]     asg_dst,
  input  logic [HW-1:0]     asg_src,
  input  logic              asg_null,
  input  logic              seen_clr,
  output logic [NUM_EV-1:0] ev_fire,
  output logic [NUM_EV-1:0] ev_seen,
  output logic [CNT_W-1:0]  drop_cnt
);

  map_entry_t        w_res;
  logic              w_imm_fire;
  logic              w_dly_req;
  logic              w_drop;
  logic [NUM_EV-1:0] w_fire_next;

  logic              r_dly_valid;
  logic [EW-1:0]     r_dly_idx;
  logic [NUM_EV-1:0] r_fire;
  logic [NUM_EV-1:0] r_seen;
  logic [CNT_W-1:0]  r_drop;

  event_handle_map #(
    .NUM_EV (NUM_EV),
    .NUM_H  (NUM_H),
    .HW     (HW)
  ) u_map (
    .clk       (clk),
    .rst       (rst),
    .asg_valid (asg_valid),
    .asg_dst   (asg_dst),
    .asg_src   (asg_src),
    .asg_null  (asg_null),
    .lk_handle (trig_handle),
    .lk_entry  (w_res)
  );

  assign w_imm_fire = trig_valid && !trig_delayed && w_res.valid;
  assign w_dly_req  = trig_valid &&  trig_delayed && w_res.valid;
  assign w_drop     = trig_valid && !w_res.valid;

  // Immediate and matured delayed fires OR together, so a collision is one pulse.
  always_comb begin
    w_fire_next = '0;
    if (w_imm_fire)  w_fire_next = w_fire_next | (NUM_EV'(1) << w_res.idx);
    if (r_dly_valid) w_fire_next = w_fire_next | (NUM_EV'(1) << r_dly_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly_valid <= 1'b0;
      r_dly_idx   <= '0;
      r_fire      <= '0;
      r_seen      <= '0;
      r_drop      <= '0;
    end else begin
      // Event index is latched now, so later table writes cannot redirect it.
      r_dly_valid <= w_dly_req;
      r_dly_idx   <= w_res.idx;
      r_fire      <= w_fire_next;
      r_seen      <= (r_seen & ~{NUM_EV{seen_clr}}) | w_fire_next;
      if (w_drop && (r_drop != {CNT_W{1'b1}})) begin
        r_drop <= r_drop + CNT_W'(1);
      end
    end
  end

  assign ev_fire  = r_fire;
  assign ev_seen  = r_seen;
  assign drop_cnt = r_drop;

endmodule
`default_nettype wire
